// File: rtl/key_pkg.sv
// key_pkg: shared widths and state encoding for the key path stages
package key_pkg;
    localparam int WORD_W    = 32;
    localparam int KEY_W     = 512;
    localparam int NUM_WORDS = KEY_W / WORD_W;
    typedef enum logic [1:0] {IDLE, LOAD, FULL} key_state_e;
endpackage

// File: rtl/key_loader.sv
// key_loader: assembles a WORD_W-word stream into a KEY_W key held until acknowledged
module key_loader #(
    parameter int WORD_W    = key_pkg::WORD_W,
    parameter int KEY_W     = key_pkg::KEY_W,
    parameter bit MSW_FIRST = 1'b1,
    localparam int NUM_WORDS = KEY_W / WORD_W,
    localparam int CNT_W     = $clog2(NUM_WORDS) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    input  logic              key_ack,
    output logic [CNT_W-1:0]  word_cnt,
    output logic              load_err
);
    import key_pkg::*;

    key_state_e       state;
    logic             accept;
    logic             last_idx;
    logic             frame_err;
    logic             wr;
    logic [CNT_W-1:0] slot;

    assign in_ready  = rst_n && state != FULL && !clear;
    assign accept    = in_valid && in_ready;
    assign last_idx  = word_cnt == CNT_W'(NUM_WORDS - 1);
    assign frame_err = accept && (in_last != last_idx);
    assign wr        = accept && !frame_err;
    assign slot      = MSW_FIRST ? CNT_W'(NUM_WORDS - 1) - word_cnt : word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_valid <= 1'b0;
            word_cnt  <= '0;
            load_err  <= 1'b0;
        end else begin
            load_err <= frame_err;
            if (clear || frame_err) begin
                state     <= IDLE;
                key_valid <= 1'b0;
                word_cnt  <= '0;
            end else if (state == FULL) begin
                if (key_ack) begin
                    state     <= IDLE;
                    key_valid <= 1'b0;
                    word_cnt  <= '0;
                end
            end else if (wr) begin
                state     <= last_idx ? FULL : LOAD;
                key_valid <= last_idx;
                word_cnt  <= word_cnt + 1'b1;
            end
        end
    end

    // The key survives an ack so downstream may keep reading it; only errors and clear zeroise
    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
        logic [WORD_W-1:0] word_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                word_q <= '0;
            else if (clear || frame_err)
                word_q <= '0;
            else if (wr && slot == CNT_W'(w))
                word_q <= in_data;
        end
        assign key[w*WORD_W +: WORD_W] = word_q;
    end
endmodule

// File: tb/tb_key_loader.sv
// tb_key_loader: randomized scoreboard bench driving MSW-first and LSW-first loaders in parallel
module tb_key_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        key_ack = 1'b0;
    logic        in_ready_m, in_ready_l, key_valid_m, key_valid_l, load_err_m, load_err_l;
    logic [511:0] key_m, key_l;
    logic [4:0]   word_cnt_m, word_cnt_l;

    key_loader #(.MSW_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_last(in_last), .key(key_m), .key_valid(key_valid_m),
        .key_ack(key_ack), .word_cnt(word_cnt_m), .load_err(load_err_m)
    );
    key_loader #(.MSW_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_last(in_last), .key(key_l), .key_valid(key_valid_l),
        .key_ack(key_ack), .word_cnt(word_cnt_l), .load_err(load_err_l)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0]  words[$];
    bit           full = 1'b0;
    int           full_age = 0;
    logic [511:0] exp_m_q[$];
    logic [511:0] exp_l_q[$];
    int           err_pend = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: a key is just the list of accepted words, laid out by word order
    task automatic model_edge(input logic v, input logic [31:0] d, input logic l, input logic a, input logic c);
        logic [511:0] km, kl;
        if (c) begin
            words.delete();
            full = 1'b0;
        end else if (full) begin
            if (a) begin
                full = 1'b0;
                words.delete();
            end
        end else if (v) begin
            if (l != (words.size() == 15)) begin
                words.delete();
                err_pend++;
            end else begin
                words.push_back(d);
                if (words.size() == 16) begin
                    km = '0;
                    kl = '0;
                    for (int i = 0; i < 16; i++) km = {km[479:0], words[i]};
                    for (int i = 15; i >= 0; i--) kl = {kl[479:0], words[i]};
                    exp_m_q.push_back(km);
                    exp_l_q.push_back(kl);
                    full = 1'b1;
                end
            end
        end
        full_age = full ? full_age + 1 : 0;
    endtask

    task automatic step(input logic v, input logic [31:0] d, input logic l, input logic a, input logic c);
        int n;
        in_valid = v;
        in_data  = d;
        in_last  = l;
        key_ack  = a;
        clear    = c;
        @(negedge clk);
        chk("in_ready_m", in_ready_m, rst_n && !full && !c);
        chk("in_ready_l", in_ready_l, rst_n && !full && !c);
        @(posedge clk);
        if (rst_n) model_edge(v, d, l, a, c);
        #1;
        in_valid = 1'b0;
        key_ack  = 1'b0;
        clear    = 1'b0;
        n = full ? 16 : words.size();
        chk("word_cnt_m", word_cnt_m, n);
        chk("word_cnt_l", word_cnt_l, n);
        chk("key_valid_m", key_valid_m, full);
        chk("key_valid_l", key_valid_l, full);
    endtask

    task automatic load(input int n, input logic [31:0] base, input bit last_at_end);
        for (int i = 0; i < n; i++) step(1'b1, base + i, last_at_end && i == n - 1, 1'b0, 1'b0);
    endtask

    logic         kv_prev = 1'b0;
    logic [511:0] held_m, held_l;

    always @(negedge clk) begin
        if (key_valid_m && !kv_prev) begin
            if (exp_m_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL key_valid_unexpected got=1 want=0");
            end else begin
                chk("key_m", key_m, exp_m_q.pop_front());
                chk("key_l", key_l, exp_l_q.pop_front());
            end
            held_m = key_m;
            held_l = key_l;
        end else if (key_valid_m) begin
            chk("hold_m", key_m, held_m);
            chk("hold_l", key_l, held_l);
        end
        if (load_err_m || load_err_l) begin
            if (err_pend == 0) begin
                checks++;
                errors++;
                $display("FAIL load_err_unexpected got=%b%b want=00", load_err_m, load_err_l);
            end else begin
                err_pend--;
                chk("load_err_both", {load_err_m, load_err_l}, 2'b11);
            end
        end
        kv_prev = key_valid_m;
    end

    initial begin
        logic [31:0] d;
        logic        l, a, c;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_key_m", key_m, '0);
        chk("rst_key_l", key_l, '0);
        chk("rst_key_valid", key_valid_m, 1'b0);
        chk("rst_word_cnt", word_cnt_m, 5'd0);
        chk("rst_load_err", load_err_m, 1'b0);
        chk("rst_in_ready", in_ready_m, 1'b0);
        rst_n = 1'b1;

        load(16, 32'h0, 1'b1);
        chk("t1_msw", key_m[511:480], 32'h0000_0000);
        chk("t1_lsw", key_m[31:0], 32'h0000_000F);
        chk("t1_in_ready", in_ready_m, 1'b0);

        repeat (5) step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        chk("t2_ready_after_ack", in_ready_m, 1'b1);
        chk("t2_key_retained", key_m, held_m);
        step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        chk("t2_word0_m", key_m[511:480], 32'hDEAD_BEEF);
        chk("t2_word0_l", key_l[31:0], 32'hDEAD_BEEF);
        load(15, $urandom, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        load(4, 32'h100, 1'b1);
        chk("t3_key_zero_m", key_m, '0);
        chk("t3_key_zero_l", key_l, '0);
        load(16, $urandom, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        load(16, 32'h200, 1'b0);
        chk("t4_key_zero", key_m, '0);

        load(9, 32'h300, 1'b0);
        step(1'b1, 32'h309, 1'b0, 1'b0, 1'b1);
        chk("t5_clear_load", key_m, '0);
        load(16, 32'h400, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("t5_clear_full_m", key_m, '0);
        chk("t5_clear_full_l", key_l, '0);

        load(5, 32'h500, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_key_m", key_m, '0);
        chk("t6_async_key_l", key_l, '0);
        chk("t6_async_cnt", word_cnt_l, 5'd0);
        chk("t6_async_ready", in_ready_l, 1'b0);
        words.delete();
        full = 1'b0;
        full_age = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (15) step(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0);
        chk("t6_l_msw", key_l[511:480], 32'hAAAA_AAAA);
        chk("t6_l_lsw", key_l[31:0], 32'h1111_1111);
        chk("t6_m_msw", key_m[511:480], 32'h1111_1111);
        chk("t6_m_lsw", key_m[31:0], 32'hAAAA_AAAA);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 2000; i++) begin
            d = $urandom;
            l = (words.size() == 15) ^ ($urandom_range(0, 15) == 0);
            a = full && full_age >= 2 && $urandom_range(0, 2) == 0;
            c = $urandom_range(0, 60) == 0;
            step($urandom_range(0, 3) != 0, d, l, a, c);
        end

        repeat (3) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("end_keys_pending", exp_m_q.size(), 0);
        chk("end_errs_pending", err_pend, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
